// File: rtl/spi_temp_pkg.sv
// Shared constants, frame layout and FSM encoding
// for the SPI temperature sensor reader.
package spi_temp_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] CS_HOLD  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] WAIT     = 3'd5;

  localparam int FRAME_BITS = 16;
  localparam int DATA_MSB   = 14;
  localparam int DATA_LSB   = 5;
  localparam int ERR_BIT    = 15;
  localparam int DATA_W     = DATA_MSB - DATA_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE,
    ST_CS_SETUP = CS_SETUP,
    ST_SHIFT    = SHIFT,
    ST_CS_HOLD  = CS_HOLD,
    ST_DONE     = DONE,
    ST_WAIT     = WAIT
  } state_t;

  function automatic logic [DATA_W-1:0] frame_code(
    input logic [FRAME_BITS-1:0] f
  );
    return f[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: CLK_DIV-cycle half periods,
// rise/fall strikes and a last-period flag.
module spi_sck_gen
  import spi_temp_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic last
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int HALVES = 2 * FRAME_BITS;
  localparam int HW = $clog2(HALVES);

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] half_cnt;
  logic          tc;

  assign tc   = run && (div_cnt == DW'(CLK_DIV - 1));
  assign rise = tc && !sck;
  assign fall = tc && sck;
  assign last = (half_cnt == HW'(HALVES - 1));

  // Counters park at zero whenever the shifter is idle
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (tc) begin
      div_cnt  <= '0;
      half_cnt <= half_cnt + HW'(1);
      sck      <= ~sck;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_temp_reader.sv
// Periodic SPI reader for a 16-bit temperature frame.
// Define SPI_TEMP_AVG4_EN to report the mean of four good frames.
module spi_temp_reader
  import spi_temp_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_spi_miso,
  output logic              o_spi_sck,
  output logic              o_spi_cs_n,
  output logic [DATA_W-1:0] o_spi_data,
  output logic              o_data_valid,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int CNT_MAX =
    (SAMPLE_PERIOD > CLK_DIV) ? SAMPLE_PERIOD : CLK_DIV;
  localparam int CW = $clog2(CNT_MAX + 1);

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [FRAME_BITS-1:0] frame;
  logic                  shift_run;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  sck_last;
  logic                  div_tc;
  logic                  wait_tc;
  logic                  done_entry;
  logic                  frame_bad;

  assign shift_run  = (state == ST_SHIFT);
  assign div_tc     = (cnt == CW'(CLK_DIV - 1));
  assign wait_tc    = (cnt == CW'(SAMPLE_PERIOD - 1));
  assign done_entry = (state == ST_CS_HOLD) && div_tc;
  assign frame_bad  = frame[ERR_BIT];

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .run   (shift_run),
    .sck   (o_spi_sck),
    .rise  (sck_rise),
    .fall  (sck_fall),
    .last  (sck_last)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (i_enable) state_n = ST_CS_SETUP;
      ST_CS_SETUP:
        if (div_tc) state_n = ST_SHIFT;
      ST_SHIFT:
        if (sck_fall && sck_last) state_n = ST_CS_HOLD;
      ST_CS_HOLD:
        if (div_tc) state_n = ST_DONE;
      ST_DONE:
        state_n = ST_WAIT;
      ST_WAIT:
        if (!i_enable) state_n = ST_IDLE;
        else if (wait_tc) state_n = ST_CS_SETUP;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // cnt restarts on every state change; it only times
  // CS_SETUP, CS_HOLD and WAIT
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      o_spi_cs_n <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || shift_run) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      o_spi_cs_n <= !(state_n inside
        {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
      o_busy <= state_n inside
        {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_DONE};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame <= '0;
    end else if (sck_rise) begin
      frame <= {frame[FRAME_BITS-2:0], i_spi_miso};
    end
  end

`ifdef SPI_TEMP_AVG4_EN
  logic [11:0] acc;
  logic [1:0]  acc_cnt;
  logic [11:0] acc_sum;

  assign acc_sum = acc + 12'(frame_code(frame));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_spi_data   <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      acc          <= '0;
      acc_cnt      <= '0;
    end else begin
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (done_entry) begin
        if (frame_bad) begin
          o_frame_err <= 1'b1;
          acc         <= '0;
          acc_cnt     <= '0;
        end else if (acc_cnt == 2'd3) begin
          o_spi_data   <= acc_sum[11:2];
          o_data_valid <= 1'b1;
          acc          <= '0;
          acc_cnt      <= '0;
        end else begin
          acc     <= acc_sum;
          acc_cnt <= acc_cnt + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_spi_data   <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (done_entry) begin
        if (frame_bad) begin
          o_frame_err <= 1'b1;
        end else begin
          o_spi_data   <= frame_code(frame);
          o_data_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_temp_reader.sv
// Directed bench for spi_temp_reader with a frame-level
// sensor model and a per-cycle reference scoreboard.
module tb_spi_temp_reader;

  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 100;
  localparam int LAT           = 34 * CLK_DIV;
  localparam int GAP_MIN       = SAMPLE_PERIOD + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       miso;
  logic       sck;
  logic       cs_n;
  logic [9:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  spi_temp_reader #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_spi_miso   (miso),
    .o_spi_sck    (sck),
    .o_spi_cs_n   (cs_n),
    .o_spi_data   (data),
    .o_data_valid (valid),
    .o_frame_err  (ferr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Sensor: presents bit 15 at CS fall, next bit on each SCK fall
  logic [15:0] word_q[$];
  logic [15:0] cur_word = 16'h0000;
  logic [3:0]  bidx = 4'd15;
  bit          frame_on = 1'b0;

  always @(posedge cs_n or negedge cs_n or negedge sck) begin
    if (cs_n !== 1'b0) begin
      frame_on = 1'b0;
    end else if (!frame_on) begin
      frame_on = 1'b1;
      cur_word = 16'h0000;
      if (word_q.size() > 0) cur_word = word_q.pop_front();
      bidx = 4'd15;
    end else if (bidx > 0) begin
      bidx = bidx - 4'd1;
    end
  end

  assign miso = cur_word[bidx];

  // Reference model, checked on every falling clock edge
  logic       rst_q = 1'b1;
  logic       cs_q = 1'b1;
  logic       sck_q = 1'b0;
  bit         pend = 1'b0;
  bit         have_rise = 1'b0;
  int         cyc = 0;
  int         due = 0;
  int         last_rise = 0;
  int         m_rises = 0;
  int         acc = 0;
  int         acnt = 0;
  logic [15:0] w = 16'h0000;
  logic [9:0]  exp_data = 10'h000;

  always @(posedge clk) rst_q <= !rst_n;

  always @(negedge clk) begin
    bit ev;
    bit ee;
    cyc++;
    ev = 1'b0;
    ee = 1'b0;
    if (rst_q) begin
      pend = 1'b0;
      have_rise = 1'b0;
      exp_data = 10'h000;
      acc = 0;
      acnt = 0;
      chk(cs_n === 1'b1, "rst_cs_n", cs_n, 1);
      chk(sck === 1'b0, "rst_sck", sck, 0);
      chk(data === 10'h000, "rst_data", data, 0);
      chk(valid === 1'b0, "rst_valid", valid, 0);
      chk(ferr === 1'b0, "rst_err", ferr, 0);
      chk(busy === 1'b0, "rst_busy", busy, 0);
    end else begin
      if (cs_q === 1'b1 && cs_n === 1'b0 && !pend) begin
        if (have_rise)
          chk(cyc - last_rise >= GAP_MIN, "m_cs_gap",
              cyc - last_rise, GAP_MIN);
        pend = 1'b1;
        due = cyc + LAT;
        m_rises = 0;
        w = cur_word;
      end
      if (pend && sck === 1'b1 && sck_q === 1'b0) m_rises++;
      chk(busy === pend, "m_busy", busy, pend);
      chk(cs_n === !(pend && cyc < due), "m_cs_n", cs_n,
          !(pend && cyc < due));
      if (pend && cyc == due) begin
        pend = 1'b0;
        have_rise = 1'b1;
        last_rise = cyc;
        chk(m_rises == 16, "m_sck_rises", m_rises, 16);
        if (w[15]) begin
          ee = 1'b1;
          acc = 0;
          acnt = 0;
        end else begin
`ifdef SPI_TEMP_AVG4_EN
          acc = acc + int'(w[14:5]);
          acnt++;
          if (acnt == 4) begin
            ev = 1'b1;
            exp_data = 10'(acc / 4);
            acc = 0;
            acnt = 0;
          end
`else
          ev = 1'b1;
          exp_data = w[14:5];
`endif
        end
      end
      chk(valid === ev, "m_valid", valid, ev);
      chk(ferr === ee, "m_frame_err", ferr, ee);
      chk(data === exp_data, "m_data", data, exp_data);
    end
    cs_q = cs_n;
    sck_q = sck;
  end

  task automatic wait_cs_fall(output int gap);
    gap = 0;
    while (cs_n !== 1'b0 && gap < 5000) begin
      @(negedge clk);
      gap++;
    end
    chk(cs_n === 1'b0, "cs_fall_wait", cs_n, 0);
  endtask

  task automatic wait_rises(input int n);
    int seen;
    int t;
    logic s_q;
    seen = 0;
    t = 0;
    s_q = sck;
    while (seen < n && t < 2000) begin
      @(negedge clk);
      t++;
      if (sck === 1'b1 && s_q === 1'b0) seen++;
      s_q = sck;
    end
    chk(seen == n, "rise_wait", seen, n);
  endtask

  task automatic wait_done(output bit v, output bit e,
                           output int lat, output int r);
    logic s_q;
    lat = 0;
    r = 0;
    s_q = sck;
    while (cs_n !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (sck === 1'b1 && s_q === 1'b0) r++;
      s_q = sck;
    end
    v = valid;
    e = ferr;
    chk(cs_n === 1'b1, "done_wait", cs_n, 1);
  endtask

  function automatic logic [15:0] mk(input logic [9:0] cd,
                                     input logic [4:0] lo);
    return {1'b0, cd, lo};
  endfunction

`ifdef SPI_TEMP_AVG4_EN
  task automatic run_avg();
    bit v;
    bit e;
    int lat;
    int gap;
    int r;
    for (int c = 'h54; c <= 'h57; c++)
      word_q.push_back(mk(10'(c), 5'h00));
    word_q.push_back(mk(10'h010, 5'h00));
    word_q.push_back(mk(10'h010, 5'h00));
    word_q.push_back(16'h8200);
    for (int i = 0; i < 3; i++)
      word_q.push_back(mk(10'h010, 5'h00));
    word_q.push_back(mk(10'h014, 5'h00));
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cs_fall(gap);
      wait_done(v, e, lat, r);
      chk(v == (i == 3), "avg_a_valid", v, i == 3);
    end
    chk(data === 10'h055, "avg_a_data", data, 'h055);
    for (int i = 0; i < 3; i++) begin
      wait_cs_fall(gap);
      wait_done(v, e, lat, r);
      chk(!v, "avg_b_valid", v, 0);
      chk(e == (i == 2), "avg_b_err", e, i == 2);
    end
    for (int i = 0; i < 4; i++) begin
      wait_cs_fall(gap);
      wait_done(v, e, lat, r);
      chk(v == (i == 3), "avg_c_valid", v, i == 3);
    end
    chk(data === 10'h011, "avg_c_data", data, 'h011);
    enable = 1'b0;
    repeat (3 * SAMPLE_PERIOD) @(negedge clk);
  endtask
`else
  task automatic run_default();
    bit v;
    bit e;
    int lat;
    int gap;
    int r;
    int lows;
    word_q.push_back(16'h0A80);
    word_q.push_back(16'h8A80);
    for (int c = 'h54; c >= 'h45; c--) begin
      logic [9:0] cd;
      cd = 10'(c);
      word_q.push_back(mk(cd, {5{cd[0]}}));
    end
    enable = 1'b1;

    wait_cs_fall(gap);
    wait_done(v, e, lat, r);
    chk(v, "f1_valid", v, 1);
    chk(!e, "f1_err", e, 0);
    chk(lat == 136, "f1_latency", lat, 136);
    chk(r == 16, "f1_sck_rises", r, 16);
    chk(data === 10'h054, "f1_data", data, 'h054);

    wait_cs_fall(gap);
    chk(gap >= GAP_MIN, "f2_gap", gap, GAP_MIN);
    wait_done(v, e, lat, r);
    chk(e, "f2_err", e, 1);
    chk(!v, "f2_valid", v, 0);
    chk(data === 10'h054, "f2_hold", data, 'h054);

    for (int c = 'h54; c >= 'h45; c--) begin
      wait_cs_fall(gap);
      chk(gap >= GAP_MIN, "sweep_gap", gap, GAP_MIN);
      wait_done(v, e, lat, r);
      chk(v && !e, "sweep_valid", v, 1);
      chk(data === 10'(c), "sweep_data", data, c);
    end

    word_q.push_back(16'h0A80);
    word_q.push_back(16'h0B00);
    wait_cs_fall(gap);
    wait_rises(8);
    rst_n = 1'b0;
    @(negedge clk);
    chk(cs_n === 1'b1, "mid_rst_cs_n", cs_n, 1);
    chk(sck === 1'b0, "mid_rst_sck", sck, 0);
    chk(data === 10'h000, "mid_rst_data", data, 0);
    chk(valid === 1'b0, "mid_rst_valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cs_fall(gap);
    wait_done(v, e, lat, r);
    chk(v, "post_rst_valid", v, 1);
    chk(data === 10'h058, "post_rst_data", data, 'h058);

    word_q.push_back(16'h0C00);
    wait_cs_fall(gap);
    wait_rises(5);
    enable = 1'b0;
    wait_done(v, e, lat, r);
    chk(v, "en_drop_valid", v, 1);
    chk(data === 10'h060, "en_drop_data", data, 'h060);
    lows = 0;
    repeat (5000) begin
      @(negedge clk);
      if (cs_n !== 1'b1) lows++;
    end
    chk(lows == 0, "en_drop_cs_idle", lows, 0);
    chk(busy === 1'b0, "en_drop_busy", busy, 0);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(data === 10'h000, "idle_data", data, 0);
    chk(cs_n === 1'b1, "idle_cs_n", cs_n, 1);
    chk(busy === 1'b0, "idle_busy", busy, 0);
`ifdef SPI_TEMP_AVG4_EN
    run_avg();
`else
    run_default();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
